// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: signal bundle between the two bus masters, the arbiter and
// the peripheral side of the 64-bit bus.
//   slave  : the arbiter's view (serves master requests, drives the bus)
//   master : the surrounding system's view (requesters plus peripherals)
interface bus_arbiter_if;
    logic        m0_req;
    logic        m0_read;
    logic        m0_write;
    logic [63:0] m0_addr;
    logic [63:0] m0_wdata;
    logic        m0_gnt;
    logic        m0_done;
    logic        m0_err;
    logic [63:0] m0_rdata;

    logic        m1_req;
    logic        m1_read;
    logic        m1_write;
    logic [63:0] m1_addr;
    logic [63:0] m1_wdata;
    logic        m1_gnt;
    logic        m1_done;
    logic        m1_err;
    logic [63:0] m1_rdata;

    logic [63:0] bus_address;
    logic [63:0] bus_wdata;
    logic [63:0] bus_rdata;
    logic        bus_read;
    logic        bus_write;
    logic [3:0]  slave_sel;
    logic [3:0]  slave_ack;

    modport slave (
        input  m0_req, m0_read, m0_write, m0_addr, m0_wdata,
        output m0_gnt, m0_done, m0_err, m0_rdata,
        input  m1_req, m1_read, m1_write, m1_addr, m1_wdata,
        output m1_gnt, m1_done, m1_err, m1_rdata,
        output bus_address, bus_wdata, bus_read, bus_write, slave_sel,
        input  bus_rdata, slave_ack
    );

    modport master (
        output m0_req, m0_read, m0_write, m0_addr, m0_wdata,
        input  m0_gnt, m0_done, m0_err, m0_rdata,
        output m1_req, m1_read, m1_write, m1_addr, m1_wdata,
        input  m1_gnt, m1_done, m1_err, m1_rdata,
        input  bus_address, bus_wdata, bus_read, bus_write, slave_sel,
        output bus_rdata, slave_ack
    );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares the 64-bit peripheral bus between m0 (processor) and
// m1 (DMA/debug). Round-robin grant, one transaction at a time, one-hot slave
// select decoded from address[SEL_LSB+1:SEL_LSB], waits for the slave ack.
// Optional wait-state timeout: define BUS_TIMEOUT_EN (limit TIMEOUT_CYCLES).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | bus free, arbitrate between pending requests
// S_CHECK | granted request latched, read/write combination validated
// S_ADDR  | strobes and slave select driven, waiting for the ack
// S_DONE  | done pulse to the owner, read data valid
// S_ERR   | done+err pulse to the owner, no strobe was issued/kept
module bus_arbiter #(
    parameter int SEL_LSB = 60
`ifdef BUS_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic         clock,
    input  logic         reset,
    bus_arbiter_if.slave bus_if
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_ADDR  = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_owner;
    logic        r_last_grant;
    logic        r_rd;
    logic        r_wr;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [63:0] r_rdata0;
    logic [63:0] r_rdata1;

    logic        w_grant;
    logic        w_grant_id;
    logic        w_ack;
    logic        w_bad_cmd;
    logic        w_timeout;
    logic [1:0]  w_index;
    logic [3:0]  w_sel;
    logic [63:0] w_rdata_cap;

    assign w_index     = r_addr[SEL_LSB+1:SEL_LSB];
    assign w_sel       = 4'b0001 << w_index;
    assign w_ack       = |(bus_if.slave_ack & w_sel);
    assign w_bad_cmd   = (r_rd == r_wr);
    assign w_rdata_cap = r_rd ? bus_if.bus_rdata : 64'd0;

`ifdef BUS_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] r_tmo_cnt;

    // Count unacknowledged ADDR cycles; cleared on the way into ADDR
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tmo_cnt <= '0;
        end else if (r_state == S_CHECK) begin
            r_tmo_cnt <= '0;
        end else if (r_state == S_ADDR && !w_ack) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // An ack in the expiry cycle still wins because w_ack is checked first
    assign w_timeout = (r_state == S_ADDR) && !w_ack &&
                       (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Arbitration and next-state decode
    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_grant_id   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus_if.m0_req && bus_if.m1_req) begin
                    w_grant    = 1'b1;
                    w_grant_id = ~r_last_grant;
                end else if (bus_if.m0_req) begin
                    w_grant    = 1'b1;
                    w_grant_id = 1'b0;
                end else if (bus_if.m1_req) begin
                    w_grant    = 1'b1;
                    w_grant_id = 1'b1;
                end
                if (w_grant) begin
                    w_state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                w_state_next = w_bad_cmd ? S_ERR : S_ADDR;
            end
            S_ADDR: begin
                if (w_ack) begin
                    w_state_next = S_DONE;
                end else if (w_timeout) begin
                    w_state_next = S_ERR;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            S_ERR:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Latch the winner's request, return read data, remember the last owner
    always_ff @(posedge clock) begin
        if (reset) begin
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_rd         <= 1'b0;
            r_wr         <= 1'b0;
            r_addr       <= 64'd0;
            r_wdata      <= 64'd0;
            r_rdata0     <= 64'd0;
            r_rdata1     <= 64'd0;
        end else begin
            if (w_grant) begin
                r_owner <= w_grant_id;
                r_addr  <= w_grant_id ? bus_if.m1_addr  : bus_if.m0_addr;
                r_wdata <= w_grant_id ? bus_if.m1_wdata : bus_if.m0_wdata;
                r_rd    <= w_grant_id ? bus_if.m1_read  : bus_if.m0_read;
                r_wr    <= w_grant_id ? bus_if.m1_write : bus_if.m0_write;
            end

            if (r_state == S_ADDR && w_ack) begin
                if (r_owner) begin
                    r_rdata1 <= w_rdata_cap;
                end else begin
                    r_rdata0 <= w_rdata_cap;
                end
            end else if (w_state_next == S_ERR) begin
                if (r_owner) begin
                    r_rdata1 <= 64'd0;
                end else begin
                    r_rdata0 <= 64'd0;
                end
            end

            if (r_state == S_DONE || r_state == S_ERR) begin
                r_last_grant <= r_owner;
            end
        end
    end

    assign bus_if.m0_gnt   = (r_state != S_IDLE) && !r_owner;
    assign bus_if.m1_gnt   = (r_state != S_IDLE) &&  r_owner;
    assign bus_if.m0_done  = (r_state == S_DONE || r_state == S_ERR) && !r_owner;
    assign bus_if.m1_done  = (r_state == S_DONE || r_state == S_ERR) &&  r_owner;
    assign bus_if.m0_err   = (r_state == S_ERR) && !r_owner;
    assign bus_if.m1_err   = (r_state == S_ERR) &&  r_owner;
    assign bus_if.m0_rdata = r_rdata0;
    assign bus_if.m1_rdata = r_rdata1;

    assign bus_if.bus_address = r_addr;
    assign bus_if.bus_wdata   = r_wdata;
    assign bus_if.bus_read    = (r_state == S_ADDR) && r_rd;
    assign bus_if.bus_write   = (r_state == S_ADDR) && r_wr;
    assign bus_if.slave_sel   = (r_state == S_ADDR) ? w_sel : 4'b0000;

endmodule
